// File: rtl/spi_master_param.sv
// Full-duplex SPI master with run-time CPOL/CPHA and one-hot selects.
// SCLK, MOSI and selects are all registered outputs of clk.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_SS  = 4,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDG_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [EDG_W-1:0] EDG_MAX = EDG_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [EDG_W-1:0]  edg;
  logic [DATA_W-1:0] sh;
  logic              cpol_q;
  logic              cpha_q;
  logic [NUM_SS-1:0] sel_dec;
  logic              tick;
  logic              lead;
  logic              samp;
  logic              last;

  assign tick = (div == DIV_MAX);
  assign lead = ~edg[0];
  assign samp = lead ^ cpha_q;
  assign last = (edg == EDG_MAX);

  // Out-of-range selects decode to no active line.
  always_comb begin
    sel_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SEL_W'(i)) sel_dec[i] = 1'b0;
    end
  end

  // Frame sequencer: setup, 2*DATA_W SCLK phases, hold, then back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      edg     <= '0;
      sh      <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss_n    <= '1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cpol_q <= cpol;
          sclk   <= cpol;
          if (start) begin
            state  <= SETUP;
            busy   <= 1'b1;
            cpha_q <= cpha;
            sh     <= tx_data;
            ss_n   <= sel_dec;
            mosi   <= cpha ? 1'b0 : tx_data[DATA_W-1];
            div    <= '0;
            edg    <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= XFER;
            div   <= '0;
          end else begin
            div <= div + 1'b1;
          end
        end
        XFER: begin
          if (tick) begin
            div  <= '0;
            sclk <= ~sclk;
            edg  <= edg + 1'b1;
            if (samp) begin
              sh <= {sh[DATA_W-2:0], miso};
            end else if (!last) begin
              mosi <= sh[DATA_W-1];
            end
            if (last) begin
              state <= HOLD;
              edg   <= '0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            state   <= IDLE;
            div     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= sh;
            ss_n    <= '1;
            mosi    <= 1'b0;
            sclk    <= cpol_q;
          end else begin
            div <= div + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: slave model plus rx/slave scoreboards.
// Second instance covers an out-of-range select with NUM_SS=3.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [1:0] ss_sel = '0;
  logic [7:0] tx_data = '0;
  logic       miso;
  logic       busy, done, sclk, mosi;
  logic [7:0] rx_data;
  logic [3:0] ss_n;

  logic       start3 = 1'b0;
  logic [1:0] ss_sel3 = 2'd3;
  logic       busy3, done3, sclk3, mosi3;
  logic [7:0] rx3;
  logic [2:0] ss_n3;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
    .ss_sel(ss_sel), .tx_data(tx_data), .miso(miso), .busy(busy),
    .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .ss_n(ss_n)
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cpol(1'b0), .cpha(1'b0),
    .ss_sel(ss_sel3), .tx_data(8'h55), .miso(1'b1), .busy(busy3),
    .done(done3), .rx_data(rx3), .sclk(sclk3), .mosi(mosi3), .ss_n(ss_n3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic       loop = 1'b0;
  logic       s_miso = 1'b0;
  logic       s_pol = 1'b0;
  logic       s_pha = 1'b0;
  logic [7:0] s_tx = '0;
  logic [7:0] s_rx = '0;
  int         s_idx = 0;
  logic       sclk_p = 1'b0;
  logic       mosi_p = 1'b0;
  logic       act_p = 1'b0;
  logic       done_p = 1'b0;
  logic       lead;
  logic       act;
  int         busy_cnt = 0;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] q_rx[$];
  logic [7:0] q_sl[$];

  assign miso = loop ? mosi : s_miso;
  assign act  = ~&ss_n;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      rise_cnt = 0;
      q_rx.delete();
      q_sl.delete();
    end else begin
      if (busy) busy_cnt++;
      if (busy && sclk && !sclk_p) rise_cnt++;
      if (done) begin
        done_cnt++;
        check("done_pulse", 32'(done_p), 0);
        if (q_rx.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          check("rx_data", 32'(rx_data), 32'(q_rx.pop_front()));
          check("slave_rx", 32'(s_rx), 32'(q_sl.pop_front()));
        end
        check("busy_cycles", busy_cnt, 36);
        check("sclk_rises", rise_cnt, 8);
        busy_cnt = 0;
        rise_cnt = 0;
      end
      if (act && !act_p) begin
        s_rx = '0;
        if (!s_pha) begin
          s_miso = s_tx[7];
          s_idx  = 6;
        end else begin
          s_idx = 7;
        end
      end else if (act && (sclk != sclk_p)) begin
        lead = (sclk_p == s_pol);
        if (lead ^ s_pha) begin
          s_rx = {s_rx[6:0], mosi};
          check("mosi_stable", 32'(mosi), 32'(mosi_p));
        end else if (s_idx >= 0) begin
          s_miso = s_tx[s_idx];
          s_idx--;
        end
      end
    end
    sclk_p = sclk;
    mosi_p = mosi;
    act_p  = act;
    done_p = done;
  end

  task automatic start_frame(input logic [7:0] tx, input logic [1:0] sel,
                             input logic pol, input logic pha,
                             input logic [7:0] sl, input logic lp);
    if (cpol != pol) begin
      cpol = pol;
      @(negedge clk);
    end
    s_pol   = pol;
    s_pha   = pha;
    s_tx    = sl;
    loop    = lp;
    cpha    = pha;
    tx_data = tx;
    ss_sel  = sel;
    q_rx.push_back(lp ? tx : sl);
    q_sl.push_back(tx);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == max) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rx"}, 32'(rx_data), 0);
    check({tag, "_sclk"}, 32'(sclk), 0);
    check({tag, "_mosi"}, 32'(mosi), 0);
    check({tag, "_ss_n"}, 32'(ss_n), 32'hF);
  endtask

  int dc0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst");
    @(negedge clk);

    // mode 0 loopback on select 1
    start_frame(8'hA5, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    check("ss_n_sel1", 32'(ss_n), 32'b1101);
    wait_done(100);
    @(negedge clk);

    // mode 3 with idle-high clock
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    check("sclk_idle_pre", 32'(sclk), 1);
    start_frame(8'hC3, 2'd0, 1'b1, 1'b1, 8'h3C, 1'b0);
    wait_done(100);
    check("sclk_idle_post", 32'(sclk), 1);
    @(negedge clk);

    // modes 1 and 2
    start_frame(8'h81, 2'd2, 1'b0, 1'b1, 8'h7E, 1'b0);
    wait_done(100);
    @(negedge clk);
    start_frame(8'h81, 2'd3, 1'b1, 1'b0, 8'h7E, 1'b0);
    wait_done(100);
    @(negedge clk);

    // starts while busy are ignored; start on done runs back-to-back
    start_frame(8'h3A, 2'd1, 1'b0, 1'b0, 8'h96, 1'b0);
    dc0 = done_cnt;
    repeat (4) @(negedge clk);
    tx_data = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    cpha = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    cpha    = 1'b0;
    tx_data = 8'h5A;
    s_tx    = 8'h69;
    q_rx.push_back(8'h69);
    q_sl.push_back(8'h5A);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    check("one_done", done_cnt - dc0, 1);
    wait_done(100);
    @(negedge clk);

    // reset mid-frame
    start_frame(8'h99, 2'd2, 1'b0, 1'b0, 8'h42, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_frame(8'h99, 2'd2, 1'b0, 1'b0, 8'h42, 1'b0);
    wait_done(100);
    @(negedge clk);

    // out-of-range select on the 3-select instance
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (10) @(negedge clk);
    check("ss3_mid_busy", 32'(busy3), 1);
    check("ss3_mid", 32'(ss_n3), 32'b111);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        if (done3) break;
        @(negedge clk);
      end
      if (i == 100) check("done3_timeout", 0, 1);
    end
    check("ss3_done", 32'(ss_n3), 32'b111);
    check("rx3", 32'(rx3), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
